// File: rtl/if_stage.sv
// Instruction-fetch stage. It generates fetch PCs and keeps at most one SRAM request outstanding.
// Returned words are buffered in a 2-entry queue ahead of ID. Branch redirects from ID are
// applied with one delay slot, and wrong-path fetches are discarded.
`timescale 1ns / 1ps

module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_allow_in,
  input  logic        id_branch_taken,
  input  logic [31:0] id_branch_target,
  output logic        if_to_id_valid,
  output logic [31:0] if_to_id_program_count,
  output logic [31:0] if_to_id_instruction,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] f0_pc_q, f0_pc_d, f0_inst_q, f0_inst_d;
  logic [31:0] f1_pc_q, f1_pc_d, f1_inst_q, f1_inst_d;
  logic [1:0]  count_q, count_d;
  logic        out_q, out_d;
  logic        out_disc_q, out_disc_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;

  logic       valid, pop, br, live_out, req, accept, push;
  logic       ds_in_fifo, kill_out, kill_acc, pend_set;
  logic [1:0] cnt_after_pop, slots;

  // Handshake, capacity and branch classification of the in-flight fetches.
  always_comb begin
    valid         = !reset && (count_q != 2'd0);
    pop           = valid && id_allow_in;
    br            = id_branch_taken && id_allow_in;
    // A discarded outstanding fetch never lands in the queue, so it does not take a slot.
    live_out      = out_q && !out_disc_q;
    cnt_after_pop = count_q - {1'b0, pop};
    slots         = cnt_after_pop + {1'b0, live_out};
    req           = !reset && (!out_q || inst_sram_data_ok) && (slots < 2'd2);
    accept        = req && inst_sram_addr_ok;
    // The queue head moves into ID alongside the branch, so it is the delay slot if present.
    ds_in_fifo    = (count_q != 2'd0);
    kill_out      = br && ds_in_fifo && live_out;
    kill_acc      = br && accept && (ds_in_fifo || live_out);
    pend_set      = br && !ds_in_fifo && !live_out && !accept;
    push          = inst_sram_data_ok && live_out && !kill_out;
  end

  assign if_to_id_valid         = valid;
  assign if_to_id_program_count = f0_pc_q;
  assign if_to_id_instruction   = f0_inst_q;
  assign inst_sram_req          = req;
  assign inst_sram_addr         = fetch_pc_q;

  // Queue next state: push/pop bookkeeping, flushed behind a delay slot taken from the head.
  always_comb begin
    f0_pc_d   = f0_pc_q;
    f0_inst_d = f0_inst_q;
    f1_pc_d   = f1_pc_q;
    f1_inst_d = f1_inst_q;
    count_d   = count_q;
    if (br && ds_in_fifo) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            f0_pc_d   = out_pc_q;
            f0_inst_d = inst_sram_rdata;
          end else begin
            f1_pc_d   = out_pc_q;
            f1_inst_d = inst_sram_rdata;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          f0_pc_d   = f1_pc_q;
          f0_inst_d = f1_inst_q;
          count_d   = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            f0_pc_d   = out_pc_q;
            f0_inst_d = inst_sram_rdata;
          end else begin
            f0_pc_d   = f1_pc_q;
            f0_inst_d = f1_inst_q;
            f1_pc_d   = out_pc_q;
            f1_inst_d = inst_sram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Outstanding-request tracking, fetch PC advance and deferred branch target.
  always_comb begin
    out_d      = out_q;
    out_pc_d   = out_pc_q;
    out_disc_d = out_disc_q;
    fetch_pc_d = fetch_pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;

    if (accept) begin
      out_d      = 1'b1;
      out_pc_d   = fetch_pc_q;
      out_disc_d = kill_acc;
    end else if (out_q && inst_sram_data_ok) begin
      out_d      = 1'b0;
      out_disc_d = 1'b0;
    end else if (kill_out) begin
      out_disc_d = 1'b1;
    end

    // Delay slot already fetched or being requested now: redirect at once.
    if (br && !pend_set) begin
      fetch_pc_d = id_branch_target;
    end else if (accept) begin
      fetch_pc_d = pend_q ? pend_tgt_q : fetch_pc_q + 32'd4;
    end

    if (pend_set) begin
      pend_d     = 1'b1;
      pend_tgt_d = id_branch_target;
    end else if (accept) begin
      pend_d = 1'b0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      f0_pc_q    <= 32'd0;
      f0_inst_q  <= 32'd0;
      f1_pc_q    <= 32'd0;
      f1_inst_q  <= 32'd0;
      count_q    <= 2'd0;
      out_q      <= 1'b0;
      out_disc_q <= 1'b0;
      out_pc_q   <= 32'd0;
      pend_q     <= 1'b0;
      pend_tgt_q <= 32'd0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      f0_pc_q    <= f0_pc_d;
      f0_inst_q  <= f0_inst_d;
      f1_pc_q    <= f1_pc_d;
      f1_inst_q  <= f1_inst_d;
      count_q    <= count_d;
      out_q      <= out_d;
      out_disc_q <= out_disc_d;
      out_pc_q   <= out_pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: a cycle-level SRAM model with variable latency, a per-cycle vector
// table, and directed sequences for stalls, branches, address wrap and reset.
`timescale 1ns / 1ps

module tb_if_stage;

  logic        clock;
  logic        reset;
  logic        id_allow_in;
  logic        id_branch_taken;
  logic [31:0] id_branch_target;
  logic        if_to_id_valid;
  logic [31:0] if_to_id_program_count;
  logic [31:0] if_to_id_instruction;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  if_stage #(.RESET_PC(32'hBFC0_0000)) u_dut (
    .clock                 (clock),
    .reset                 (reset),
    .id_allow_in           (id_allow_in),
    .id_branch_taken       (id_branch_taken),
    .id_branch_target      (id_branch_target),
    .if_to_id_valid        (if_to_id_valid),
    .if_to_id_program_count(if_to_id_program_count),
    .if_to_id_instruction  (if_to_id_instruction),
    .inst_sram_req         (inst_sram_req),
    .inst_sram_addr        (inst_sram_addr),
    .inst_sram_addr_ok     (inst_sram_addr_ok),
    .inst_sram_data_ok     (inst_sram_data_ok),
    .inst_sram_rdata       (inst_sram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        allow;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_req;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t tbl [15];

  int n_cmp = 0;
  int n_err = 0;

  // SRAM model state
  int          lat;
  logic        m_busy;
  logic [31:0] m_addr;
  int          m_wait;

  // Samples from the most recent cycle
  logic        s_valid, s_req;
  logic [31:0] s_pc, s_inst, s_addr;

  logic [31:0] pop_q [$];
  logic [31:0] acc_q [$];
  logic [31:0] exp_b [6];
  logic [31:0] exp_c [6];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample at negedge, advance the SRAM model after posedge.
  task automatic cyc(input logic rst, input logic allow, input logic aok, input logic br,
                     input logic [31:0] tgt);
    logic dok;
    reset             = rst;
    id_allow_in       = allow;
    inst_sram_addr_ok = aok;
    id_branch_taken   = br;
    id_branch_target  = tgt;
    @(negedge clock);
    s_valid = if_to_id_valid;
    s_pc    = if_to_id_program_count;
    s_inst  = if_to_id_instruction;
    s_req   = inst_sram_req;
    s_addr  = inst_sram_addr;
    dok     = inst_sram_data_ok;
    if (!rst && s_valid && allow) begin
      pop_q.push_back(s_pc);
      check("instruction word", s_inst, mem_word(s_pc));
    end
    if (!rst && s_req && aok) acc_q.push_back(s_addr);
    @(posedge clock);
    #1;
    if (rst) begin
      m_busy = 1'b0;
    end else begin
      if (dok) m_busy = 1'b0;
      if (s_req && aok) begin
        m_busy = 1'b1;
        m_addr = s_addr;
        m_wait = lat - 1;
      end else if (m_busy && m_wait > 0) begin
        m_wait--;
      end
    end
    inst_sram_data_ok = m_busy && (m_wait == 0);
    inst_sram_rdata   = inst_sram_data_ok ? mem_word(m_addr) : 32'hDEAD_BEEF;
  endtask

  task automatic do_reset();
    lat = 1;
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    pop_q.delete();
    acc_q.delete();
  endtask

  // Brings up a stream whose first instruction (BFC00000) branches to tgt from ID.
  task automatic branch_from_first(input logic [31:0] tgt);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, tgt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; id_allow_in = 1'b1; id_branch_taken = 1'b0; id_branch_target = 32'h0;
    inst_sram_addr_ok = 1'b1; inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'hDEAD_BEEF;
    m_busy = 1'b0; m_addr = 32'h0; m_wait = 0; lat = 1;

    // rst, allow, exp_valid, exp_pc, exp_req, exp_addr
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'hBFC0_0000};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'hBFC0_0004};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 32'hBFC0_0000, 1'b1, 32'hBFC0_0008};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 32'hBFC0_0004, 1'b1, 32'hBFC0_000C};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 32'hBFC0_0008, 1'b1, 32'hBFC0_0010};
    for (int i = 7; i < 12; i++) tbl[i] = '{1'b0, 1'b0, 1'b1, 32'hBFC0_000C, 1'b0, 32'h0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 32'hBFC0_000C, 1'b1, 32'hBFC0_0014};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 32'hBFC0_0010, 1'b1, 32'hBFC0_0018};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 32'hBFC0_0014, 1'b1, 32'hBFC0_001C};

    exp_b = '{32'hBFC0_0000, 32'hBFC0_0004, 32'h100, 32'h104, 32'h200, 32'h204};
    exp_c = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hFC, 32'h100, 32'h104, 32'h200};

    // Reset, streaming fetch, then a 5-cycle ID stall.
    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].rst, tbl[i].allow, 1'b1, 1'b0, 32'h0);
      check($sformatf("vec%0d valid", i), {31'd0, s_valid}, {31'd0, tbl[i].exp_valid});
      if (tbl[i].exp_valid) check($sformatf("vec%0d pc", i), s_pc, tbl[i].exp_pc);
      check($sformatf("vec%0d req", i), {31'd0, s_req}, {31'd0, tbl[i].exp_req});
      if (tbl[i].exp_req) check($sformatf("vec%0d addr", i), s_addr, tbl[i].exp_addr);
    end

    // addr_ok held low: address stable, exactly one request and one word.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      check("A req held", {31'd0, s_req}, 32'd1);
      check("A addr stable", s_addr, 32'hBFC0_0000);
    end
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("A accepted count", 32'(acc_q.size()), 32'd1);
    check("A delivered count", 32'(pop_q.size()), 32'd1);
    check("A delivered pc", pop_q[0], 32'hBFC0_0000);

    // Branch at 0x100 -> 0x200 with 0x104 queued and 0x108 outstanding.
    do_reset();
    branch_from_first(32'h100);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    lat = 3;
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
    lat = 1;
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    check("B delivered count", 32'(pop_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) check($sformatf("B pop%0d", i), pop_q[i], exp_b[i]);
    check("B req after 0x108", acc_q[7], 32'h200);

    // Branch at 0x100 -> 0x200 with nothing queued or requested: delay slot fetched first.
    do_reset();
    branch_from_first(32'hFC);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h200);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    check("C delivered count", 32'(pop_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) check($sformatf("C pop%0d", i), pop_q[i], exp_c[i]);
    check("C delay-slot req", acc_q[6], 32'h104);
    check("C target req", acc_q[7], 32'h200);

    // Wrap from 0xFFFFFFFC to 0, then reset while a fetch is outstanding.
    do_reset();
    branch_from_first(32'hFFFF_FFFC);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    lat = 3;
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    check("D head before reset", s_pc, 32'hFFFF_FFFC);
    check("D wrap req", acc_q[4], 32'hFFFF_FFFC);
    check("D wrapped req", acc_q[5], 32'h0000_0000);
    lat = 1;
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("D reset valid", {31'd0, s_valid}, 32'd0);
    check("D reset req", {31'd0, s_req}, 32'd0);
    pop_q.delete();
    acc_q.delete();
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    check("D post-reset valid", {31'd0, s_valid}, 32'd0);
    check("D post-reset req", {31'd0, s_req}, 32'd1);
    check("D post-reset addr", s_addr, 32'hBFC0_0000);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    check("D post-reset first pc", pop_q[0], 32'hBFC0_0000);
    check("D post-reset second pc", pop_q[1], 32'hBFC0_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
